// File: rtl/slv_guard_rst_seq.sv
// slv_guard_rst_seq: per-subordinate reset sequencer that isolates the port, drains, pulses reset,
// waits for the subordinate to leave reset, then reopens the port.
module slv_guard_rst_seq #(
    parameter int unsigned CntWidth     = 16,
    parameter int unsigned MinRstCycles = 8,
    parameter int unsigned EvtCntWidth  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rst_req_i,
    input  logic [CntWidth-1:0]    drain_budget_i,
    input  logic [CntWidth-1:0]    release_budget_i,
    output logic                   isolate_o,
    input  logic                   isolated_i,
    output logic                   sub_rst_no,
    input  logic                   rst_stat_i,
    output logic                   busy_o,
    output logic                   fault_o,
    output logic                   irq_o,
    input  logic                   irq_clr_i,
    output logic [EvtCntWidth-1:0] rst_cnt_o
);
    typedef enum logic [2:0] {IDLE, ISOLATE, ASSERT, RELEASE, REOPEN, FAULT} state_e;
    localparam logic [CntWidth-1:0] MinCnt = CntWidth'(MinRstCycles - 1);
    state_e                 state_q, state_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic                   isolate_q, isolate_d;
    logic                   sub_rst_n_q, sub_rst_n_d;
    logic                   busy_q, busy_d;
    logic                   fault_q, fault_d;
    logic                   irq_q, irq_d;
    logic [EvtCntWidth-1:0] rst_cnt_q, rst_cnt_d;
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        isolate_d   = isolate_q;
        sub_rst_n_d = sub_rst_n_q;
        fault_d     = fault_q;
        irq_d       = irq_clr_i ? 1'b0 : irq_q;
        rst_cnt_d   = rst_cnt_q;
        case (state_q)
            IDLE: if (rst_req_i) begin
                state_d   = ISOLATE;
                cnt_d     = '0;
                isolate_d = 1'b1;
            end
            ISOLATE: if (isolated_i || cnt_q == drain_budget_i) begin
                state_d     = ASSERT;
                cnt_d       = '0;
                sub_rst_n_d = 1'b0;
            end else cnt_d = cnt_q + 1'b1;
            // Counter parks at the minimum so an unresponsive subordinate cannot wrap it.
            ASSERT: if (cnt_q >= MinCnt && rst_stat_i) begin
                state_d     = RELEASE;
                cnt_d       = '0;
                sub_rst_n_d = 1'b1;
            end else if (cnt_q < MinCnt) cnt_d = cnt_q + 1'b1;
            RELEASE: if (!rst_stat_i) state_d = REOPEN;
            else if (cnt_q == release_budget_i) begin
                state_d = FAULT;
                fault_d = 1'b1;
                irq_d   = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
            REOPEN: begin
                state_d   = IDLE;
                isolate_d = 1'b0;
                irq_d     = 1'b1;
                rst_cnt_d = &rst_cnt_q ? rst_cnt_q : rst_cnt_q + 1'b1;
            end
            FAULT: if (irq_clr_i) begin
                state_d     = ASSERT;
                cnt_d       = '0;
                sub_rst_n_d = 1'b0;
                fault_d     = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            isolate_q   <= 1'b0;
            sub_rst_n_q <= 1'b1;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
            irq_q       <= 1'b0;
            rst_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            isolate_q   <= isolate_d;
            sub_rst_n_q <= sub_rst_n_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
            irq_q       <= irq_d;
            rst_cnt_q   <= rst_cnt_d;
        end
    end
    assign isolate_o  = isolate_q;
    assign sub_rst_no = sub_rst_n_q;
    assign busy_o     = busy_q;
    assign fault_o    = fault_q;
    assign irq_o      = irq_q;
    assign rst_cnt_o  = rst_cnt_q;
endmodule
